// File: rtl/cerradura_pkg.sv
// Shared types and helpers for the keypad lock controller.
package cerradura_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } state_e;

  // Width of the shared down-counter: wide enough for the longest of the
  // three timed intervals, plus one bit of headroom.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/cerradura_timer.sv
// Loadable down-counter shared by the entry, open, programming and lockout
// intervals. It saturates at zero; done is high while the count is zero.
module cerradura_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;

  // Count down once per cycle; a load always takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/cerradura_param_fsm.sv
// Electronic lock controller: checks a CODE_LEN-digit sequence against a
// programmable code, counts failures, enforces a lockout penalty and
// auto-relocks. One timer instance serves all timed states.
module cerradura_param_fsm
  import cerradura_pkg::*;
#(
  parameter int                          DIGIT_W        = 4,
  parameter int                          CODE_LEN       = 3,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE   = 12'h987,
  parameter int                          MAX_ERRORS     = 3,
  parameter int                          ENTRY_TIMEOUT  = 1000,
  parameter int                          UNLOCK_CYCLES  = 5000,
  parameter int                          LOCKOUT_CYCLES = 10000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DIGIT_W-1:0]                tecla,
  input  logic                              pushed,
  input  logic                              lock_req,
  input  logic                              prog_req,
  output logic                              unlock,
  output logic                              error,
  output logic                              lockout,
  output logic                              prog_mode,
  output logic [$clog2(MAX_ERRORS+1)-1:0]   err_cnt,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_idx
);

  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int CNT_W  = $clog2(MAX_ERRORS + 1);
  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int TMR_W  = timer_w(ENTRY_TIMEOUT, UNLOCK_CYCLES, LOCKOUT_CYCLES);

  // The timer expires when it reaches zero, so loading N-1 gives exactly N
  // cycles in the timed state.
  localparam logic [TMR_W-1:0] LD_ENTRY   = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LD_UNLOCK  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CODE_LEN - 1);
  localparam logic [CNT_W-1:0] ERR_LIMIT  = CNT_W'(MAX_ERRORS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                mismatch_q, mismatch_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [DIGIT_W-1:0]  shadow_q [CODE_LEN];
  logic [DIGIT_W-1:0]  shadow_d [CODE_LEN];
  logic [DIGIT_W-1:0]  code_digit [CODE_LEN];
  logic                error_d;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done;
  logic                miss;
  logic [CNT_W-1:0]    err_inc;

  cerradura_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Split the stored code into digits for the per-key comparison.
  always_comb begin
    for (int i = 0; i < CODE_LEN; i++) begin
      code_digit[i] = code_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  assign miss    = mismatch_q | (tecla != code_digit[idx_q]);
  assign err_inc = err_q + CNT_W'(1);

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    error_d    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (pushed) begin
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!miss) begin
              state_d  = ST_OPEN;
              err_d    = '0;
              tmr_load = 1'b1;
              tmr_val  = LD_UNLOCK;
            end else begin
              error_d = 1'b1;
              err_d   = err_inc;
              if (err_inc == ERR_LIMIT) begin
                state_d  = ST_LOCKOUT;
                tmr_load = 1'b1;
                tmr_val  = LD_LOCKOUT;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            mismatch_d = miss;
            state_d    = ST_ENTRY;
            tmr_load   = 1'b1;
            tmr_val    = LD_ENTRY;
          end
        end else if (state_q == ST_ENTRY && tmr_done) begin
          // Abandoned entry: discard silently, failure count untouched.
          state_d    = ST_IDLE;
          idx_d      = '0;
          mismatch_d = 1'b0;
        end
      end

      ST_OPEN: begin
        if (lock_req) begin
          state_d = ST_IDLE;
        end else if (prog_req) begin
          state_d  = ST_PROG;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = LD_ENTRY;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_PROG: begin
        if (lock_req) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (pushed) begin
          shadow_d[idx_q] = tecla;
          if (idx_q == LAST_IDX) begin
            for (int i = 0; i < CODE_LEN; i++) begin
              code_d[i*DIGIT_W +: DIGIT_W] = shadow_d[i];
            end
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
            tmr_val  = LD_ENTRY;
          end
        end else if (tmr_done) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          err_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, counters, code and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      code_q     <= DEFAULT_CODE;
      unlock     <= 1'b0;
      error      <= 1'b0;
      lockout    <= 1'b0;
      prog_mode  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      code_q     <= code_d;
      unlock     <= (state_d == ST_OPEN) || (state_d == ST_PROG);
      error      <= error_d;
      lockout    <= (state_d == ST_LOCKOUT);
      prog_mode  <= (state_d == ST_PROG);
    end
  end

  // Shadow digits for code programming.
  always_ff @(posedge clk) begin
    // NOTE: the shadow is left without reset on purpose: it only reaches
    // code_q after all CODE_LEN digits of one session have been written.
    shadow_q <= shadow_d;
  end

  assign err_cnt   = err_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_cerradura_param_fsm.sv
// Directed self-checking bench for the keypad lock controller.
module tb_cerradura_param_fsm;

  localparam int DIGIT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [DIGIT_W-1:0] tecla = '0;
  logic               pushed = 1'b0;
  logic               lock_req = 1'b0;
  logic               prog_req = 1'b0;
  logic               unlock, error, lockout, prog_mode;
  logic [1:0]         err_cnt;
  logic [1:0]         digit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cerradura_param_fsm #(
    .DIGIT_W        (4),
    .CODE_LEN       (3),
    .DEFAULT_CODE   (12'h987),
    .MAX_ERRORS     (3),
    .ENTRY_TIMEOUT  (12),
    .UNLOCK_CYCLES  (16),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tecla     (tecla),
    .pushed    (pushed),
    .lock_req  (lock_req),
    .prog_req  (prog_req),
    .unlock    (unlock),
    .error     (error),
    .lockout   (lockout),
    .prog_mode (prog_mode),
    .err_cnt   (err_cnt),
    .digit_idx (digit_idx)
  );

  typedef struct {
    logic [3:0] k0, k1, k2;
    int         exp_unlock;
    int         exp_error;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    tecla  = d;
    pushed = 1'b1;
    tick();
    pushed = 1'b0;
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press(a);
    press(b);
    press(c);
  endtask

  task automatic relock();
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
  endtask

  int n;

  initial begin
    vecs[0] = '{4'd7, 4'd8, 4'd9, 1, 0, 0};
    vecs[1] = '{4'd7, 4'd5, 4'd9, 0, 1, 1};
    vecs[2] = '{4'd1, 4'd8, 4'd9, 0, 1, 2};
    vecs[3] = '{4'd7, 4'd8, 4'd9, 1, 0, 0};
    vecs[4] = '{4'd7, 4'd8, 4'd0, 0, 1, 1};
    vecs[5] = '{4'd7, 4'd8, 4'd9, 1, 0, 0};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset unlock", int'(unlock), 0);
    check("reset error", int'(error), 0);
    check("reset lockout", int'(lockout), 0);
    check("reset prog_mode", int'(prog_mode), 0);
    check("reset err_cnt", int'(err_cnt), 0);
    check("reset digit_idx", int'(digit_idx), 0);
    rst_n = 1'b1;
    tick();

    // Table of complete three-key attempts.
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].k0);
      press(vecs[i].k1);
      check($sformatf("vec%0d digit_idx mid", i), int'(digit_idx), 2);
      check($sformatf("vec%0d early error", i), int'(error), 0);
      press(vecs[i].k2);
      check($sformatf("vec%0d unlock", i), int'(unlock), vecs[i].exp_unlock);
      check($sformatf("vec%0d error", i), int'(error), vecs[i].exp_error);
      check($sformatf("vec%0d err_cnt", i), int'(err_cnt), vecs[i].exp_cnt);
      check($sformatf("vec%0d digit_idx end", i), int'(digit_idx), 0);
      if (vecs[i].exp_unlock != 0) begin
        relock();
        check($sformatf("vec%0d relock", i), int'(unlock), 0);
      end else begin
        tick();
        check($sformatf("vec%0d error width", i), int'(error), 0);
      end
    end

    // Auto-relock: open for exactly 16 cycles.
    enter(4'd7, 4'd8, 4'd9);
    n = 0;
    while (unlock && n < 40) begin
      tick();
      n++;
    end
    check("open duration", n, 16);
    check("open error never", int'(error), 0);

    // Manual relock presented in the fifth open cycle.
    enter(4'd7, 4'd8, 4'd9);
    repeat (4) tick();
    check("open cycle5 unlock", int'(unlock), 1);
    relock();
    check("lock_req drop", int'(unlock), 0);

    // Wrong middle digit: verdict only after the last key.
    press(4'd7);
    press(4'd5);
    check("no error after 5", int'(error), 0);
    press(4'd9);
    check("error after 9", int'(error), 1);
    check("err_cnt after 759", int'(err_cnt), 1);
    tick();
    check("error one cycle", int'(error), 0);

    // Entry timeout, with a key landing on the expiry cycle.
    press(4'd7);
    repeat (11) tick();
    press(4'd8);
    check("push beats expiry", int'(digit_idx), 2);
    repeat (11) tick();
    check("entry before expiry", int'(digit_idx), 2);
    tick();
    check("entry expired idx", int'(digit_idx), 0);
    check("expiry err_cnt kept", int'(err_cnt), 1);
    check("expiry no error", int'(error), 0);
    enter(4'd7, 4'd8, 4'd9);
    check("unlock after timeout", int'(unlock), 1);
    check("err_cnt cleared", int'(err_cnt), 0);
    relock();

    // Three failures: lockout for 20 cycles, keys ignored meanwhile.
    enter(4'd1, 4'd1, 4'd1);
    enter(4'd1, 4'd1, 4'd1);
    enter(4'd1, 4'd1, 4'd1);
    check("lockout rise", int'(lockout), 1);
    check("lockout error", int'(error), 1);
    check("lockout err_cnt", int'(err_cnt), 3);
    enter(4'd7, 4'd8, 4'd9);
    check("lockout ignores keys", int'(unlock), 0);
    n = 3;
    while (lockout && n < 60) begin
      tick();
      n++;
    end
    check("lockout duration", n, 20);
    check("post lockout err_cnt", int'(err_cnt), 0);
    check("post lockout idx", int'(digit_idx), 0);
    enter(4'd7, 4'd8, 4'd9);
    check("unlock after lockout", int'(unlock), 1);
    relock();

    // Reprogram the code to 1,2,3.
    enter(4'd7, 4'd8, 4'd9);
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    check("prog_mode rise", int'(prog_mode), 1);
    check("prog unlock", int'(unlock), 1);
    enter(4'd1, 4'd2, 4'd3);
    check("prog commit mode", int'(prog_mode), 0);
    check("prog commit relock", int'(unlock), 0);
    enter(4'd7, 4'd8, 4'd9);
    check("old code rejected", int'(error), 1);
    check("old code locked", int'(unlock), 0);
    tick();
    enter(4'd1, 4'd2, 4'd3);
    check("new code opens", int'(unlock), 1);
    check("new code err_cnt", int'(err_cnt), 0);

    // Aborted programming keeps 1,2,3.
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    press(4'd4);
    press(4'd5);
    relock();
    check("prog abort mode", int'(prog_mode), 0);
    check("prog abort unlock", int'(unlock), 0);
    enter(4'd1, 4'd2, 4'd3);
    check("code kept after abort", int'(unlock), 1);
    relock();

    // Reset in the middle of programming restores the default code.
    enter(4'd1, 4'd2, 4'd3);
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    press(4'd4);
    check("mid prog idx", int'(digit_idx), 1);
    rst_n = 1'b0;
    #2;
    check("rst unlock", int'(unlock), 0);
    check("rst prog_mode", int'(prog_mode), 0);
    check("rst lockout", int'(lockout), 0);
    check("rst error", int'(error), 0);
    check("rst digit_idx", int'(digit_idx), 0);
    check("rst err_cnt", int'(err_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    enter(4'd7, 4'd8, 4'd9);
    check("default code restored", int'(unlock), 1);
    check("default code no error", int'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
